weight_stream_buffer: RTL and testbench

WEIGHT_STREAM_BUFFER -- requirements
Module: weight_stream_buffer

---
 rtl/weight_stream_buffer_pkg.sv | 16 +
 rtl/weight_stream_buffer_fifo.sv | 92 +++++++++
 rtl/weight_stream_buffer.sv | 115 +++++++++++
 tb/tb_weight_stream_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_stream_buffer_pkg.sv
// Shared accelerator definitions for the weight streaming path.
//   WEIGHT_W     : width of one weight word from the read master
//   TILE_LEN_W   : width of the tile length field
//   tile_state_e : tile sequencing state of weight_stream_buffer
package weight_stream_buffer_pkg;

    localparam int unsigned WEIGHT_W   = 1024;
    localparam int unsigned TILE_LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } tile_state_e;

endpackage

// File: rtl/weight_stream_buffer_fifo.sv
// Show-ahead weight FIFO: storage, wrapping pointers, occupancy, throttle
// and sticky overflow.
//   clk, rst_n        : clock, synchronous active-low reset
//   wr_req, wr_data   : offered word (no backpressure; dropped when full)
//   pop               : head word consumed this cycle
//   head              : current head word, combinational from storage
//   occupancy         : registered word count
//   occupancy_next_c  : word count after this cycle's push/pop
//   almost_full       : registered occupancy >= AF_LEVEL
//   overflow          : sticky, a word was dropped
module weight_fifo
    import weight_stream_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_req,
    input  logic [WEIGHT_W-1:0]     wr_data,
    input  logic                    pop,
    output logic [WEIGHT_W-1:0]     head,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [$clog2(DEPTH):0]  occupancy_next_c,
    output logic                    almost_full,
    output logic                    overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WEIGHT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [OCC_W-1:0]    occ_q;
    logic [OCC_W-1:0]    occ_next;
    logic                almost_full_q;
    logic                overflow_q;
    logic                full;
    logic                pop_ok;
    logic                push;
    logic                drop;

    // Push/pop qualification; a pop frees a slot for a same-cycle push.
    always_comb begin
        full     = (occ_q == OCC_W'(DEPTH));
        pop_ok   = pop && (occ_q != '0);
        push     = wr_req && (!full || pop_ok);
        drop     = wr_req && full && !pop_ok;
        occ_next = occ_q;
        if (push && !pop_ok) begin
            occ_next = occ_q + OCC_W'(1);
        end else if (!push && pop_ok) begin
            occ_next = occ_q - OCC_W'(1);
        end
    end

    // Control state; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            occ_q         <= occ_next;
            almost_full_q <= (occ_next >= OCC_W'(AF_LEVEL));
            overflow_q    <= overflow_q | drop;
        end
    end

    // Storage is deliberately not reset; head is don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign head             = mem[rd_ptr_q];
    assign occupancy        = occ_q;
    assign occupancy_next_c = occ_next;
    assign almost_full      = almost_full_q;
    assign overflow         = overflow_q;

endmodule

// File: rtl/weight_stream_buffer.sv
// Weight stream buffer: queues weight words from the read master and
// releases exactly one tile's worth to the PE array per tile_start.
//   clk, rst_n             : clock, synchronous active-low reset
//   data_read, data_valid  : weight words from the read master
//   tile_start, tile_len   : begin a tile of tile_len words
//   pe_weight, pe_valid    : head word to the PE array
//   pe_ready               : PE array accepts the head word
//   almost_full            : throttle to the controller
//   occupancy              : queued word count
//   busy, tile_done        : tile in progress / last word accepted
//   overflow               : sticky, a word was dropped
module weight_stream_buffer
    import weight_stream_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WEIGHT_W-1:0]     data_read,
    input  logic                    data_valid,
    input  logic                    tile_start,
    input  logic [TILE_LEN_W-1:0]   tile_len,
    output logic [WEIGHT_W-1:0]     pe_weight,
    output logic                    pe_valid,
    input  logic                    pe_ready,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    busy,
    output logic                    tile_done,
    output logic                    overflow
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    tile_state_e           state_q;
    tile_state_e           state_next;
    logic [TILE_LEN_W-1:0] remaining_q;
    logic [TILE_LEN_W-1:0] remaining_next;
    logic                  pe_valid_q;
    logic                  pe_valid_next;
    logic                  busy_q;
    logic                  tile_done_q;
    logic                  pop;
    logic [OCC_W-1:0]      occ_next;

    assign pop = pe_valid_q && pe_ready;

    weight_fifo #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) u_fifo (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_req           (data_valid),
        .wr_data          (data_read),
        .pop              (pop),
        .head             (pe_weight),
        .occupancy        (occupancy),
        .occupancy_next_c (occ_next),
        .almost_full      (almost_full),
        .overflow         (overflow)
    );

    // Tile sequencing; pe_valid is registered from next state and next
    // occupancy so it equals (state==STREAM && occupancy!=0) each cycle.
    always_comb begin
        state_next     = state_q;
        remaining_next = remaining_q;
        case (state_q)
            IDLE: begin
                if (tile_start && (tile_len != '0)) begin
                    state_next     = STREAM;
                    remaining_next = tile_len;
                end
            end
            STREAM: begin
                if (pop) begin
                    remaining_next = remaining_q - TILE_LEN_W'(1);
                    if (remaining_q == TILE_LEN_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        pe_valid_next = (state_next == STREAM) && (occ_next != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            pe_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_next;
            remaining_q <= remaining_next;
            pe_valid_q  <= pe_valid_next;
            busy_q      <= (state_next != IDLE);
            tile_done_q <= (state_next == DONE);
        end
    end

    assign pe_valid  = pe_valid_q;
    assign busy      = busy_q;
    assign tile_done = tile_done_q;

endmodule

// File: tb/tb_weight_stream_buffer.sv
// Directed self-checking bench for weight_stream_buffer (DEPTH=8, AF_LEVEL=5).
module tb_weight_stream_buffer;
    import weight_stream_buffer_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic [WEIGHT_W-1:0]   data_read;
    logic                  data_valid;
    logic                  tile_start;
    logic [TILE_LEN_W-1:0] tile_len;
    logic [WEIGHT_W-1:0]   pe_weight;
    logic                  pe_valid;
    logic                  pe_ready;
    logic                  almost_full;
    logic [3:0]            occupancy;
    logic                  busy;
    logic                  tile_done;
    logic                  overflow;

    int checks   = 0;
    int failures = 0;

    weight_stream_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_read   (data_read),
        .data_valid  (data_valid),
        .tile_start  (tile_start),
        .tile_len    (tile_len),
        .pe_weight   (pe_weight),
        .pe_valid    (pe_valid),
        .pe_ready    (pe_ready),
        .almost_full (almost_full),
        .occupancy   (occupancy),
        .busy        (busy),
        .tile_done   (tile_done),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are observed and inputs driven 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [WEIGHT_W-1:0] obs, input logic [WEIGHT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        data_read  = '0;
        data_valid = 1'b0;
        tile_start = 1'b0;
        tile_len   = '0;
        pe_ready   = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_pe_valid", 32'(pe_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(tile_done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step();

        // Prefetch 0..7 in IDLE, then stream a tile of 8
        for (int i = 0; i < 8; i++) begin
            data_valid = 1'b1;
            data_read  = WEIGHT_W'(i);
            step();
            chk("fill_occ", 32'(occupancy), 32'(i + 1));
            chk("fill_af", 32'(almost_full), 32'((i + 1) >= 5));
            chk("fill_pe_valid_idle", 32'(pe_valid), 32'd0);
        end
        data_valid = 1'b0;
        tile_start = 1'b1;
        tile_len   = 16'd8;
        pe_ready   = 1'b1;
        step();
        tile_start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t1_pe_valid", 32'(pe_valid), 32'd1);
            chk_w("t1_word", pe_weight, WEIGHT_W'(i));
            chk("t1_occ", 32'(occupancy), 32'(8 - i));
            chk("t1_af", 32'(almost_full), 32'((8 - i) >= 5));
            chk("t1_done_early", 32'(tile_done), 32'd0);
            step();
        end
        chk("t1_done", 32'(tile_done), 32'd1);
        chk("t1_pe_valid_done", 32'(pe_valid), 32'd0);
        chk("t1_busy_done", 32'(busy), 32'd1);
        chk("t1_occ_end", 32'(occupancy), 32'd0);
        chk("t1_af_end", 32'(almost_full), 32'd0);
        step();
        chk("t1_done_pulse", 32'(tile_done), 32'd0);
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // Overflow: 9 pushes into DEPTH=8
        pe_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            data_valid = 1'b1;
            data_read  = WEIGHT_W'(100 + i);
            step();
            chk("ovf_occ", 32'(occupancy), 32'((i < 8) ? (i + 1) : 8));
            chk("ovf_flag", 32'(overflow), 32'(i == 8));
        end
        data_valid = 1'b0;
        tile_start = 1'b1;
        tile_len   = 16'd8;
        pe_ready   = 1'b1;
        step();
        tile_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_w("ovf_word", pe_weight, WEIGHT_W'(100 + i));
            step();
        end
        chk("ovf_done", 32'(tile_done), 32'd1);
        chk("ovf_occ_end", 32'(occupancy), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        step();
        chk("ovf_sticky2", 32'(overflow), 32'd1);
        rst_n = 1'b0;
        step();
        chk("ovf_cleared", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step();

        // Full FIFO with simultaneous push and pop loses nothing
        pe_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data_valid = 1'b1;
            data_read  = WEIGHT_W'(200 + i);
            step();
        end
        data_valid = 1'b0;
        chk("full_occ", 32'(occupancy), 32'd8);
        tile_start = 1'b1;
        tile_len   = 16'd12;
        step();
        tile_start = 1'b0;
        pe_ready   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("pp_pe_valid", 32'(pe_valid), 32'd1);
            chk_w("pp_word", pe_weight, WEIGHT_W'(200 + i));
            chk("pp_occ", 32'(occupancy), 32'((i <= 4) ? 8 : (12 - i)));
            chk("pp_ovf", 32'(overflow), 32'd0);
            data_valid = (i < 4);
            data_read  = WEIGHT_W'(208 + i);
            step();
        end
        data_valid = 1'b0;
        chk("pp_done", 32'(tile_done), 32'd1);
        chk("pp_occ_end", 32'(occupancy), 32'd0);
        chk("pp_ovf_end", 32'(overflow), 32'd0);
        step();

        // Reset mid-tile, then a 1-word tile
        pe_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1;
            data_read  = WEIGHT_W'(300 + i);
            step();
        end
        data_valid = 1'b0;
        tile_start = 1'b1;
        tile_len   = 16'd3;
        pe_ready   = 1'b1;
        step();
        tile_start = 1'b0;
        chk_w("mid_word0", pe_weight, WEIGHT_W'(300));
        step();
        chk_w("mid_word1", pe_weight, WEIGHT_W'(301));
        step();
        rst_n = 1'b0;
        step();
        chk("mid_pe_valid", 32'(pe_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(tile_done), 32'd0);
        chk("mid_occ", 32'(occupancy), 32'd0);
        chk("mid_af", 32'(almost_full), 32'd0);
        chk("mid_ovf", 32'(overflow), 32'd0);
        rst_n    = 1'b1;
        pe_ready = 1'b0;
        step();
        chk("mid_no_done", 32'(tile_done), 32'd0);
        chk("mid_idle", 32'(busy), 32'd0);
        data_valid = 1'b1;
        data_read  = WEIGHT_W'(400);
        tile_start = 1'b1;
        tile_len   = 16'd1;
        pe_ready   = 1'b1;
        step();
        data_valid = 1'b0;
        tile_start = 1'b0;
        chk("one_pe_valid", 32'(pe_valid), 32'd1);
        chk_w("one_word", pe_weight, WEIGHT_W'(400));
        chk("one_busy", 32'(busy), 32'd1);
        step();
        chk("one_done", 32'(tile_done), 32'd1);
        chk("one_pe_valid_done", 32'(pe_valid), 32'd0);
        step();
        chk("one_done_pulse", 32'(tile_done), 32'd0);
        chk("one_busy_idle", 32'(busy), 32'd0);
        chk("one_occ", 32'(occupancy), 32'd0);

        // Zero-length tile ignored; tile_start during STREAM ignored
        tile_start = 1'b1;
        tile_len   = 16'd0;
        step();
        tile_start = 1'b0;
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_done", 32'(tile_done), 32'd0);
        step();
        chk("zero_done2", 32'(tile_done), 32'd0);
        chk("zero_busy2", 32'(busy), 32'd0);
        pe_ready   = 1'b0;
        tile_start = 1'b1;
        tile_len   = 16'd2;
        step();
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_pe_valid_empty", 32'(pe_valid), 32'd0);
        tile_len = 16'd5;
        step();
        tile_start = 1'b0;
        chk("ign_busy2", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1;
            data_read  = WEIGHT_W'(500 + i);
            step();
            chk("ign_pe_valid", 32'(pe_valid), 32'd1);
        end
        data_valid = 1'b0;
        pe_ready   = 1'b1;
        chk_w("ign_word0", pe_weight, WEIGHT_W'(500));
        step();
        chk_w("ign_word1", pe_weight, WEIGHT_W'(501));
        chk("ign_done_early", 32'(tile_done), 32'd0);
        step();
        chk("ign_done", 32'(tile_done), 32'd1);
        chk("ign_occ_left", 32'(occupancy), 32'd1);
        chk("ign_pe_valid_done", 32'(pe_valid), 32'd0);
        step();
        chk("ign_idle_busy", 32'(busy), 32'd0);
        chk("ign_idle_pe_valid", 32'(pe_valid), 32'd0);
        chk("ign_idle_occ", 32'(occupancy), 32'd1);
        chk("ign_done_pulse", 32'(tile_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
